// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: sensor/control inputs and coin-code outputs of coin_acceptor.
// COIN_COUNT_EN adds the per-type emitted-coin totals.
interface coin_acceptor_if;
   logic       sense;
   logic       accept_en;
   logic [1:0] coin;
   logic       reject;
   logic       jam;
   logic       fifo_full;
`ifdef COIN_COUNT_EN
   logic [15:0] small_total;
   logic [15:0] large_total;
   modport master(output sense, accept_en, input coin, reject, jam, fifo_full, small_total, large_total);
   modport slave(input sense, accept_en, output coin, reject, jam, fifo_full, small_total, large_total);
`else
   modport master(output sense, accept_en, input coin, reject, jam, fifo_full);
   modport slave(input sense, accept_en, output coin, reject, jam, fifo_full);
`endif
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces the coin sensor, classifies coins by beam-block width and queues codes.
// Optional macro COIN_COUNT_EN adds small_total/large_total emitted-coin counters.
module coin_acceptor #(
   parameter int CW        = 8,
   parameter int DEB_CYC   = 4,
   parameter int SMALL_MIN = 8,
   parameter int SMALL_MAX = 15,
   parameter int LARGE_MIN = 20,
   parameter int LARGE_MAX = 31,
   parameter int JAM_CYC   = 64,
   parameter int DEPTH     = 4,
   parameter int GAP       = 2
) (
   input logic         clk,
   input logic         rst_n,
   coin_acceptor_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY, JAM} state_t;
   state_t        state_q, state_d;
   logic          s1_q, s2_q, deb_q, deb_d;
   logic [CW-1:0] dcnt_q, dcnt_d, wcnt_q, wcnt_d, gap_q, gap_d;
   logic [1:0]    mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [1:0]    coin_q, coin_d, code;
   logic          push, pop, rej, full;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign pop  = cnt_q != '0 && bus.accept_en && gap_q == '0;
   always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      if (s2_q != deb_q) begin
         dcnt_d = dcnt_q + 1'b1;
         if (dcnt_q == CW'(DEB_CYC - 1)) begin
            deb_d  = s2_q;
            dcnt_d = '0;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      code    = 2'd0;
      rej     = 1'b0;
      case (state_q)
         IDLE: if (deb_q) begin
            state_d = MEASURE;
            wcnt_d  = CW'(1);
         end
         MEASURE: if (!deb_q) state_d = CLASSIFY;
         else begin
            wcnt_d  = (wcnt_q == CW'(JAM_CYC)) ? wcnt_q : wcnt_q + 1'b1;
            state_d = (wcnt_d == CW'(JAM_CYC)) ? JAM : MEASURE;
         end
         CLASSIFY: begin
            code    = (wcnt_q >= CW'(SMALL_MIN) && wcnt_q <= CW'(SMALL_MAX)) ? 2'd1 :
                      (wcnt_q >= CW'(LARGE_MIN) && wcnt_q <= CW'(LARGE_MAX)) ? 2'd2 : 2'd0;
            // a valid coin only fits a full FIFO when a pop frees a slot this cycle
            rej     = code == 2'd0 || (full && !pop);
            state_d = IDLE;
         end
         JAM: if (!deb_q) begin
            state_d = IDLE;
            rej     = 1'b1;
         end
      endcase
   end
   assign push = code != 2'd0 && !rej;
   always_comb begin
      cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      gap_d  = pop ? CW'(GAP) : (gap_q != '0) ? gap_q - 1'b1 : gap_q;
      coin_d = pop ? mem_q[rp_q] : 2'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         deb_q   <= 1'b0;
         dcnt_q  <= '0;
         state_q <= IDLE;
         wcnt_q  <= '0;
         gap_q   <= '0;
         cnt_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         coin_q  <= 2'd0;
      end else begin
         s1_q    <= bus.sense;
         s2_q    <= s1_q;
         deb_q   <= deb_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         wp_q    <= push ? wp_q + 1'b1 : wp_q;
         rp_q    <= pop ? rp_q + 1'b1 : rp_q;
         coin_q  <= coin_d;
      end
   end
   always_ff @(posedge clk) if (push) mem_q[wp_q] <= code;
   assign bus.coin      = coin_q;
   assign bus.reject    = rej;
   assign bus.jam       = state_q == JAM;
   assign bus.fifo_full = full;
`ifdef COIN_COUNT_EN
   logic [15:0] small_q, large_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         small_q <= '0;
         large_q <= '0;
      end else begin
         small_q <= (pop && mem_q[rp_q] == 2'd1) ? small_q + 1'b1 : small_q;
         large_q <= (pop && mem_q[rp_q] == 2'd2) ? large_q + 1'b1 : large_q;
      end
   end
   assign bus.small_total = small_q;
   assign bus.large_total = large_q;
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed and randomized coin insertions checked against a coin-level model.
module tb_coin_acceptor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0, n_pass = 0;
   int   got[$], expq[$], pend[$];
   int   n_rej = 0, er = 0, last_t = -100, min_gap = 1000, cyc = 0;
   bit   stall = 1'b0;
   coin_acceptor_if bus();
   coin_acceptor dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (bus.reject) n_rej++;
         if (bus.coin != 2'd0) begin
            got.push_back(int'(bus.coin));
            if (cyc - last_t < min_gap) min_gap = cyc - last_t;
            last_t = cyc;
         end
      end
   end
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask
   // coin outcome from width: 0 filtered, 1 small, 2 large, 3 returned
   function automatic int cls(int w);
      if (w < 4) return 0;
      if (w >= 8 && w <= 15) return 1;
      if (w >= 20 && w <= 31) return 2;
      return 3;
   endfunction
   task automatic ins(int w);
      int c;
      c = cls(w);
      bus.sense = 1'b1;
      repeat (w) @(negedge clk);
      bus.sense = 1'b0;
      repeat (30) @(negedge clk);
      if (c == 3) er++;
      else if (c != 0) begin
         if (!stall) expq.push_back(c);
         else if (pend.size() < 4) pend.push_back(c);
         else er++;
      end
   endtask
   task automatic drain();
      bus.accept_en = 1'b1;
      stall = 1'b0;
      repeat (40) @(negedge clk);
      foreach (pend[i]) expq.push_back(pend[i]);
      pend.delete();
   endtask
   task automatic check_stream(string tag);
      check({tag, "_ncoins"}, got.size(), expq.size());
      for (int i = 0; i < expq.size() && i < got.size(); i++) check({tag, "_code"}, got[i], expq[i]);
      check({tag, "_rejects"}, n_rej, er);
      check({tag, "_gap"}, min_gap >= 3, 1);
   endtask
   initial begin
      bus.sense = 1'b0;
      bus.accept_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_coin", bus.coin, 0);
      check("rst_reject", bus.reject, 0);
      check("rst_jam", bus.jam, 0);
      check("rst_full", bus.fifo_full, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      ins(12);
      check_stream("t1_small");
      ins(25);
      check_stream("t2_large");
      ins(2);
      check_stream("t2_glitch");
`ifdef COIN_COUNT_EN
      check("small_total", bus.small_total, 1);
      check("large_total", bus.large_total, 1);
`endif
      ins(17);
      check_stream("t3_between");
      bus.accept_en = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ins(12);
         if (i == 2) check("t4_full3", bus.fifo_full, 0);
         if (i == 3) check("t4_full4", bus.fifo_full, 1);
      end
      check_stream("t4_held");
      drain();
      check("t4_empty", bus.fifo_full, 0);
      check_stream("t4_drain");
      bus.sense = 1'b1;
      repeat (60) @(negedge clk);
      check("t5_nojam", bus.jam, 0);
      repeat (15) @(negedge clk);
      check("t5_jam", bus.jam, 1);
      repeat (5) @(negedge clk);
      bus.sense = 1'b0;
      repeat (30) @(negedge clk);
      er++;
      check("t5_jam_clear", bus.jam, 0);
      check_stream("t5_jam");
      for (int i = 0; i < 20; i++) ins($urandom_range(40, 2));
      check_stream("rnd_free");
      for (int r = 0; r < 2; r++) begin
         bus.accept_en = 1'b0;
         stall = 1'b1;
         for (int k = $urandom_range(7, 3); k > 0; k--) ins($urandom_range(35, 4));
         check_stream("rnd_held");
         drain();
         check_stream("rnd_drain");
      end
      bus.sense = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("t6_coin", bus.coin, 0);
      check("t6_reject", bus.reject, 0);
      bus.sense = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check_stream("t6_mid");
      bus.accept_en = 1'b0;
      stall = 1'b1;
      ins(12);
      ins(12);
      #2 rst_n = 1'b0;
      #1 check("t6q_coin", bus.coin, 0);
      check("t6q_full", bus.fifo_full, 0);
      pend.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drain();
      check_stream("t6_queued");
      ins(12);
      check_stream("t6_after");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
